// File: rtl/apb_modport_pkg.sv
// Shared constants and state type for the APB master/slave subsystem.
package apb_modport_pkg;

  localparam int unsigned AW        = 9;
  localparam int unsigned DW        = 8;
  localparam int unsigned MEM_DEPTH = 2 ** (AW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mem_slave.sv
// Zero-wait-state APB memory slave: writes commit at the ACCESS edge,
// reads return memory contents combinationally during ACCESS.
module apb_mem_slave #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic [DATA_W-1:0] i_pwdata,
  output logic [DATA_W-1:0] o_prdata,
  output logic              o_pready
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_access;

  assign w_access = i_psel & i_penable;
  assign o_pready = w_access;

  // Reset clears every word so that an aborted write leaves no trace.
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[ADDR_W'(i)] <= '0;
      end
    end else if (w_access && i_pwrite) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

  always_comb begin
    o_prdata = '0;
    if (w_access && !i_pwrite) begin
      o_prdata = r_mem[i_paddr];
    end
  end

endmodule

// File: rtl/apb_modport.sv
// APB subsystem top: request-to-APB master FSM, two memory slaves selected
// by the address MSB, and a registered read-data output.
module apb_modport
  import apb_modport_pkg::*;
(
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  input  logic [AW-1:0] apb_read_paddr,
  output logic [DW-1:0] apb_read_data_out
);

  apb_state_e    r_state;
  logic          r_psel;
  logic          r_penable;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_rdata;

  logic          w_sel2;
  logic          w_psel1;
  logic          w_psel2;
  logic          w_pready1;
  logic          w_pready2;
  logic          w_pready;
  logic [DW-1:0] w_prdata1;
  logic [DW-1:0] w_prdata2;
  logic [DW-1:0] w_prdata;

  assign w_sel2   = r_paddr[AW-1];
  assign w_psel1  = r_psel & ~w_sel2;
  assign w_psel2  = r_psel &  w_sel2;
  assign w_pready = w_sel2 ? w_pready2 : w_pready1;
  assign w_prdata = w_sel2 ? w_prdata2 : w_prdata1;

  assign apb_read_data_out = r_rdata;

  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (transfer) begin
            r_state   <= SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= ~read_write;
            r_paddr   <= read_write ? apb_read_paddr : apb_write_paddr;
            r_pwdata  <= apb_write_data;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (w_pready) begin
            if (!r_pwrite) begin
              r_rdata <= w_prdata;
            end
            // Back-to-back: the next request is captured on the completing edge.
            if (transfer) begin
              r_state   <= SETUP;
              r_penable <= 1'b0;
              r_pwrite  <= ~read_write;
              r_paddr   <= read_write ? apb_read_paddr : apb_write_paddr;
              r_pwdata  <= apb_write_data;
            end else begin
              r_state   <= IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  apb_mem_slave #(
    .ADDR_W (AW - 1),
    .DATA_W (DW),
    .DEPTH  (MEM_DEPTH)
  ) u_slave1 (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_psel    (w_psel1),
    .i_penable (r_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[AW-2:0]),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata1),
    .o_pready  (w_pready1)
  );

  apb_mem_slave #(
    .ADDR_W (AW - 1),
    .DATA_W (DW),
    .DEPTH  (MEM_DEPTH)
  ) u_slave2 (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_psel    (w_psel2),
    .i_penable (r_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[AW-2:0]),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata2),
    .o_pready  (w_pready2)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Scoreboard bench for apb_modport: stimulus pushes the expected read-data
// output and the cycle it is due; a monitor pops and compares on negedges.
module tb_apb_modport;

  logic       pclk;
  logic       presetn;
  logic       transfer;
  logic       read_write;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_read_data_out;

  apb_modport dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int unsigned due;
    logic [7:0]  exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cycle = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  mem_model [512];
  logic [7:0]  last_rd;

  always @(posedge pclk) cycle <= cycle + 1;

  always @(negedge pclk) begin
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.due < cycle) begin
        errors++;
        $display("FAIL %s: check missed (due %0d, now %0d)", e.name, e.due, cycle);
      end else if (apb_read_data_out !== e.exp) begin
        errors++;
        $display("FAIL %s: read_data_out got %h expected %h", e.name, apb_read_data_out, e.exp);
      end
    end
  end

  // Drive one request at the current negedge and update the reference model.
  task automatic issue(input bit rd, input logic [8:0] a, input logic [7:0] d,
                       input bit chk, input string nm);
    transfer   = 1'b1;
    read_write = rd;
    apb_write_data = d;
    if (rd) begin
      apb_read_paddr  = a;
      apb_write_paddr = 9'h1AA;
      last_rd = mem_model[a];
    end else begin
      apb_write_paddr = a;
      apb_read_paddr  = 9'h1AA;
      mem_model[a] = d;
    end
    if (chk) sb.push_back('{cycle + 3, last_rd, nm});
  endtask

  task automatic single(input bit rd, input logic [8:0] a, input logic [7:0] d,
                        input string nm);
    issue(rd, a, d, 1'b1, nm);
    @(negedge pclk);
    transfer = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) mem_model[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  initial begin
    transfer = 1'b0;
    read_write = 1'b0;
    apb_write_paddr = '0;
    apb_write_data = '0;
    apb_read_paddr = '0;
    model_reset();

    // 1: reset state and unwritten location
    presetn = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b0;
    sb.push_back('{cycle + 1, 8'h00, "reset_out"});
    @(negedge pclk);
    single(1'b1, 9'h000, 8'h00, "rd_000_after_reset");
    single(1'b1, 9'h1FE, 8'h00, "rd_1FE_unwritten");

    // 2: write/read slave 1
    single(1'b0, 9'h005, 8'hA5, "wr_005_hold");
    single(1'b1, 9'h005, 8'h00, "rd_005");

    // 3: slave isolation
    single(1'b0, 9'h105, 8'h3C, "wr_105_hold");
    single(1'b1, 9'h005, 8'h00, "rd_005_iso");
    single(1'b1, 9'h105, 8'h00, "rd_105");

    // 4: continuous transfer, one completion per two cycles
    issue(1'b0, 9'h0FF, 8'h11, 1'b1, "b2b_wr_11");
    repeat (2) @(negedge pclk);
    issue(1'b1, 9'h0FF, 8'h00, 1'b1, "b2b_rd_11");
    repeat (2) @(negedge pclk);
    issue(1'b0, 9'h0FF, 8'h22, 1'b1, "b2b_wr_22");
    repeat (2) @(negedge pclk);
    issue(1'b1, 9'h0FF, 8'h00, 1'b1, "b2b_rd_22");
    repeat (2) @(negedge pclk);
    issue(1'b1, 9'h105, 8'h00, 1'b1, "b2b_rd_105");
    @(negedge pclk);
    transfer = 1'b0;
    repeat (2) @(negedge pclk);

    // 5: inputs changed during SETUP do not affect the transfer
    issue(1'b0, 9'h010, 8'h77, 1'b1, "wr_010_hold");
    @(negedge pclk);
    transfer = 1'b0;
    apb_write_data  = 8'hEE;
    apb_write_paddr = 9'h011;
    @(negedge pclk);
    @(negedge pclk);
    single(1'b1, 9'h010, 8'h00, "rd_010");
    single(1'b1, 9'h011, 8'h00, "rd_011_untouched");

    // 6: reset during ACCESS aborts the write and clears everything
    issue(1'b0, 9'h020, 8'h55, 1'b0, "wr_020_abort");
    @(negedge pclk);
    transfer = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    model_reset();
    @(negedge pclk);
    presetn = 1'b0;
    sb.push_back('{cycle + 1, 8'h00, "midreset_out"});
    @(negedge pclk);
    single(1'b1, 9'h020, 8'h00, "rd_020_after_abort");
    single(1'b1, 9'h005, 8'h00, "rd_005_cleared");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge pclk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never checked (due %0d, now %0d)", e.name, e.due, cycle);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
